// File: rtl/bm1387_job_dispatcher.sv
// BM1387 job dispatcher: hands host jobs to the ASIC, collects found nonces and keeps statistics.
// Optional RUN-state watchdog is compiled in when BM1387_DISPATCH_WATCHDOG_EN is defined.
module bm1387_job_dispatcher #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter int          STAT_WIDTH     = 16
) (
  input  logic                  clk_100m,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [255:0]          job_header,
  input  logic [31:0]           job_start_nonce,
  input  logic [31:0]           job_nonce_range,
  input  logic                  host_abort,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [31:0]           result_nonce,
  output logic [255:0]          result_hash,
  output logic                  job_done,
  output logic [1:0]            job_done_code,
  output logic [255:0]          asic_job_header,
  output logic [31:0]           asic_start_nonce,
  output logic [31:0]           asic_nonce_range,
  output logic                  asic_mining_enable,
  output logic [7:0]            asic_control_reg,
  input  logic                  asic_hash_valid,
  input  logic                  asic_pipeline_busy,
  input  logic                  asic_thermal_throttle,
  input  logic [31:0]           asic_found_nonce,
  input  logic [255:0]          asic_found_hash,
  input  logic [7:0]            asic_status_reg,
  output logic [STAT_WIDTH-1:0] jobs_completed,
  output logic [STAT_WIDTH-1:0] nonces_found,
  output logic [STAT_WIDTH-1:0] throttle_cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_RESULT = 3'd3,
    S_ACK    = 3'd4,
    S_FINISH = 3'd5,
    S_ABORT  = 3'd6
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        timeout_hit;
  logic        job_ready_nxt;
  logic        enable_nxt;
  logic [7:0]  control_nxt;
  logic        result_valid_nxt;
  logic        job_done_nxt;
  logic [1:0]  done_code_nxt;
  logic        job_accept;
  logic        result_capture;
  logic        result_accept;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
    if (&value) begin
      sat_inc = value;
    end else begin
      sat_inc = value + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

`ifdef BM1387_DISPATCH_WATCHDOG_EN
  logic [31:0] wd_count;

  // Watchdog: zero outside RUN, frozen while the ASIC throttles.
  always_ff @(posedge clk_100m) begin
    if (reset) begin
      wd_count <= 32'd0;
    end else if (state != S_RUN) begin
      wd_count <= 32'd0;
    end else if (asic_thermal_throttle) begin
      wd_count <= wd_count;
    end else begin
      wd_count <= wd_count + 32'd1;
    end
  end

  assign timeout_hit = (state == S_RUN) && (wd_count == (TIMEOUT_CYCLES - 32'd1));
`else
  // The limit has no effect without the watchdog.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  assign job_accept     = (state == S_IDLE) && job_valid && job_ready;
  assign result_capture = (state == S_RUN) && (state_next == S_RESULT);
  assign result_accept  = (state == S_RESULT) && (state_next == S_ACK);

  // State register.
  always_ff @(posedge clk_100m) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; host_abort outranks every ASIC event.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (job_valid && job_ready) state_next = S_START;
        else                        state_next = S_IDLE;
      end
      S_START: begin
        if (host_abort)              state_next = S_ABORT;
        else if (asic_pipeline_busy) state_next = S_RUN;
        else                         state_next = S_START;
      end
      S_RUN: begin
        if (host_abort)                      state_next = S_ABORT;
        else if (asic_hash_valid)            state_next = S_RESULT;
        else if (asic_status_reg == 8'h03)   state_next = S_FINISH;
        else if (timeout_hit)                state_next = S_ABORT;
        else                                 state_next = S_RUN;
      end
      S_RESULT: begin
        if (host_abort)                        state_next = S_ABORT;
        else if (result_valid && result_ready) state_next = S_ACK;
        else                                   state_next = S_RESULT;
      end
      S_ACK: begin
        if (host_abort)            state_next = S_ABORT;
        else if (!asic_hash_valid) state_next = S_FINISH;
        else                       state_next = S_ACK;
      end
      S_FINISH: begin
        if (host_abort)               state_next = S_ABORT;
        else if (!asic_pipeline_busy) state_next = S_IDLE;
        else                          state_next = S_FINISH;
      end
      S_ABORT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode of the state being entered, so every output comes straight from a flop.
  always_comb begin
    job_ready_nxt    = 1'b0;
    enable_nxt       = 1'b0;
    control_nxt      = 8'h00;
    result_valid_nxt = 1'b0;
    job_done_nxt     = 1'b0;
    done_code_nxt    = job_done_code;
    case (state_next)
      S_IDLE: begin
        job_ready_nxt = 1'b1;
        job_done_nxt  = (state == S_FINISH);
      end
      S_START, S_RUN: begin
        enable_nxt  = 1'b1;
        control_nxt = 8'h01;
      end
      S_RESULT: begin
        enable_nxt       = 1'b1;
        control_nxt      = 8'h01;
        result_valid_nxt = 1'b1;
      end
      S_ACK: begin
        enable_nxt  = 1'b1;
        control_nxt = 8'h03;
      end
      S_FINISH: begin
        enable_nxt  = 1'b1;
        control_nxt = 8'h01;
        if (state == S_RUN)      done_code_nxt = 2'b10;
        else if (state == S_ACK) done_code_nxt = 2'b01;
        else                     done_code_nxt = job_done_code;
      end
      S_ABORT: begin
        job_done_nxt  = 1'b1;
        done_code_nxt = 2'b11;
      end
      default: begin
        job_ready_nxt = 1'b0;
      end
    endcase
  end

  // Output, job-field and result registers.
  always_ff @(posedge clk_100m) begin
    if (reset) begin
      job_ready          <= 1'b0;
      asic_mining_enable <= 1'b0;
      asic_control_reg   <= 8'h00;
      result_valid       <= 1'b0;
      job_done           <= 1'b0;
      job_done_code      <= 2'b00;
      asic_job_header    <= 256'd0;
      asic_start_nonce   <= 32'd0;
      asic_nonce_range   <= 32'd0;
      result_nonce       <= 32'd0;
      result_hash        <= 256'd0;
    end else begin
      job_ready          <= job_ready_nxt;
      asic_mining_enable <= enable_nxt;
      asic_control_reg   <= control_nxt;
      result_valid       <= result_valid_nxt;
      job_done           <= job_done_nxt;
      job_done_code      <= done_code_nxt;
      if (job_accept) begin
        asic_job_header  <= job_header;
        asic_start_nonce <= job_start_nonce;
        asic_nonce_range <= job_nonce_range;
      end
      if (result_capture) begin
        result_nonce <= asic_found_nonce;
        result_hash  <= asic_found_hash;
      end
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk_100m) begin
    if (reset) begin
      jobs_completed  <= {STAT_WIDTH{1'b0}};
      nonces_found    <= {STAT_WIDTH{1'b0}};
      throttle_cycles <= {STAT_WIDTH{1'b0}};
    end else begin
      if (job_done_nxt) jobs_completed <= sat_inc(jobs_completed);
      if (result_accept) nonces_found <= sat_inc(nonces_found);
      if (asic_thermal_throttle && (state != S_IDLE)) throttle_cycles <= sat_inc(throttle_cycles);
    end
  end

endmodule

// File: tb/tb_bm1387_job_dispatcher.sv
// Directed bench for bm1387_job_dispatcher; the ASIC side is driven by hand.
// Timeout expectations follow BM1387_DISPATCH_WATCHDOG_EN.
module tb_bm1387_job_dispatcher;

  logic         clk_100m;
  logic         reset;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_header;
  logic [31:0]  job_start_nonce;
  logic [31:0]  job_nonce_range;
  logic         host_abort;
  logic         result_valid;
  logic         result_ready;
  logic [31:0]  result_nonce;
  logic [255:0] result_hash;
  logic         job_done;
  logic [1:0]   job_done_code;
  logic [255:0] asic_job_header;
  logic [31:0]  asic_start_nonce;
  logic [31:0]  asic_nonce_range;
  logic         asic_mining_enable;
  logic [7:0]   asic_control_reg;
  logic         asic_hash_valid;
  logic         asic_pipeline_busy;
  logic         asic_thermal_throttle;
  logic [31:0]  asic_found_nonce;
  logic [255:0] asic_found_hash;
  logic [7:0]   asic_status_reg;
  logic [15:0]  jobs_completed;
  logic [15:0]  nonces_found;
  logic [15:0]  throttle_cycles;

  int   vectors;
  int   miscompares;
  logic rv_seen;
  logic rv_clear;

  bm1387_job_dispatcher #(
    .TIMEOUT_CYCLES(32'd100),
    .STAT_WIDTH    (16)
  ) dut (
    .clk_100m             (clk_100m),
    .reset                (reset),
    .job_valid            (job_valid),
    .job_ready            (job_ready),
    .job_header           (job_header),
    .job_start_nonce      (job_start_nonce),
    .job_nonce_range      (job_nonce_range),
    .host_abort           (host_abort),
    .result_valid         (result_valid),
    .result_ready         (result_ready),
    .result_nonce         (result_nonce),
    .result_hash          (result_hash),
    .job_done             (job_done),
    .job_done_code        (job_done_code),
    .asic_job_header      (asic_job_header),
    .asic_start_nonce     (asic_start_nonce),
    .asic_nonce_range     (asic_nonce_range),
    .asic_mining_enable   (asic_mining_enable),
    .asic_control_reg     (asic_control_reg),
    .asic_hash_valid      (asic_hash_valid),
    .asic_pipeline_busy   (asic_pipeline_busy),
    .asic_thermal_throttle(asic_thermal_throttle),
    .asic_found_nonce     (asic_found_nonce),
    .asic_found_hash      (asic_found_hash),
    .asic_status_reg      (asic_status_reg),
    .jobs_completed       (jobs_completed),
    .nonces_found         (nonces_found),
    .throttle_cycles      (throttle_cycles)
  );

  always #5 clk_100m = ~clk_100m;

  // Sticky record of any result_valid during a job.
  always @(posedge clk_100m) begin
    if (rv_clear) rv_seen <= 1'b0;
    else if (result_valid) rv_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge in IDLE; returns on the negedge of the first RUN cycle.
  task automatic start_job(input logic [255:0] hdr, input logic [31:0] sn, input logic [31:0] rng);
    job_valid       = 1'b1;
    job_header      = hdr;
    job_start_nonce = sn;
    job_nonce_range = rng;
    @(negedge clk_100m);
    check("start_job_ready_low", {255'd0, job_ready}, 256'd0);
    check("start_asic_nonce", {224'd0, asic_start_nonce}, {224'd0, sn});
    check("start_asic_range", {224'd0, asic_nonce_range}, {224'd0, rng});
    check("start_asic_header", asic_job_header, hdr);
    check("start_control", {248'd0, asic_control_reg}, 256'h01);
    job_valid          = 1'b0;
    asic_pipeline_busy = 1'b1;
    @(negedge clk_100m);
  endtask

  initial begin
    clk_100m = 1'b0;
    reset = 1'b1;
    rv_clear = 1'b1;
    vectors = 0;
    miscompares = 0;
    job_valid = 1'b0;
    job_header = 256'd0;
    job_start_nonce = 32'd0;
    job_nonce_range = 32'd0;
    host_abort = 1'b0;
    result_ready = 1'b0;
    asic_hash_valid = 1'b0;
    asic_pipeline_busy = 1'b0;
    asic_thermal_throttle = 1'b0;
    asic_found_nonce = 32'd0;
    asic_found_hash = 256'd0;
    asic_status_reg = 8'h00;

    repeat (3) @(negedge clk_100m);
    check("rst_job_ready", {255'd0, job_ready}, 256'd0);
    check("rst_enable", {255'd0, asic_mining_enable}, 256'd0);
    reset = 1'b0;
    rv_clear = 1'b0;
    @(negedge clk_100m);
    check("post_rst_job_ready", {255'd0, job_ready}, 256'd1);
    check("idle_control", {248'd0, asic_control_reg}, 256'h00);

    // Range exhausted; a job_valid offered during RUN must be ignored.
    start_job({8{32'hA5A5_0001}}, 32'h1000, 32'd16);
    job_valid = 1'b1;
    job_start_nonce = 32'h9999;
    asic_status_reg = 8'h01;
    repeat (3) @(negedge clk_100m);
    check("stray_job_not_taken", {224'd0, asic_start_nonce}, 256'h1000);
    check("run_job_ready_low", {255'd0, job_ready}, 256'd0);
    check("run_control", {248'd0, asic_control_reg}, 256'h01);
    job_valid = 1'b0;
    asic_status_reg = 8'h03;
    @(negedge clk_100m);
    check("exhaust_code", {254'd0, job_done_code}, 256'd2);
    check("finish_enable", {255'd0, asic_mining_enable}, 256'd1);
    check("finish_no_done_yet", {255'd0, job_done}, 256'd0);
    asic_status_reg = 8'h00;
    asic_pipeline_busy = 1'b0;
    @(negedge clk_100m);
    check("exhaust_done_pulse", {255'd0, job_done}, 256'd1);
    check("exhaust_jobs_completed", {240'd0, jobs_completed}, 256'd1);
    check("exhaust_enable_off", {255'd0, asic_mining_enable}, 256'd0);
    check("exhaust_control_off", {248'd0, asic_control_reg}, 256'h00);
    check("exhaust_no_result", {255'd0, rv_seen}, 256'd0);
    @(negedge clk_100m);
    check("exhaust_done_one_cycle", {255'd0, job_done}, 256'd0);

    // Found nonce, host stalls result_ready for 50 cycles.
    start_job({8{32'hA5A5_0002}}, 32'h1000, 32'd16);
    asic_hash_valid = 1'b1;
    asic_found_nonce = 32'h1005;
    asic_found_hash = {8{32'hC0FF_EE05}};
    @(negedge clk_100m);
    asic_found_nonce = 32'hDEAD_BEEF;
    asic_found_hash = {8{32'h1234_5678}};
    check("found_hash", result_hash, {8{32'hC0FF_EE05}});
    for (int i = 0; i < 50; i++) begin
      check("stall_result_valid", {255'd0, result_valid}, 256'd1);
      check("stall_result_nonce", {224'd0, result_nonce}, 256'h1005);
      check("stall_ack_withheld", {248'd0, asic_control_reg}, 256'h01);
      @(negedge clk_100m);
    end
    result_ready = 1'b1;
    @(negedge clk_100m);
    result_ready = 1'b0;
    check("ack_result_valid_low", {255'd0, result_valid}, 256'd0);
    check("ack_control", {248'd0, asic_control_reg}, 256'h03);
    check("ack_nonces_found", {240'd0, nonces_found}, 256'd1);
    repeat (3) begin
      @(negedge clk_100m);
      check("ack_control_held", {248'd0, asic_control_reg}, 256'h03);
    end
    asic_hash_valid = 1'b0;
    @(negedge clk_100m);
    check("found_code", {254'd0, job_done_code}, 256'd1);
    check("found_control_run", {248'd0, asic_control_reg}, 256'h01);
    asic_pipeline_busy = 1'b0;
    @(negedge clk_100m);
    check("found_done_pulse", {255'd0, job_done}, 256'd1);
    check("found_jobs_completed", {240'd0, jobs_completed}, 256'd2);
    @(negedge clk_100m);

    // Stalled ASIC, thermal throttle for the first 20 RUN cycles.
    start_job({8{32'hA5A5_0003}}, 32'h5000_0000, 32'hFFFF_FFFF);
    asic_thermal_throttle = 1'b1;
    repeat (20) @(negedge clk_100m);
    asic_thermal_throttle = 1'b0;
    repeat (99) @(negedge clk_100m);
    check("wd_still_running", {255'd0, asic_mining_enable}, 256'd1);
    check("wd_no_done_yet", {255'd0, job_done}, 256'd0);
    @(negedge clk_100m);
    check("throttle_cycles", {240'd0, throttle_cycles}, 256'd20);
`ifdef BM1387_DISPATCH_WATCHDOG_EN
    check("wd_done_pulse", {255'd0, job_done}, 256'd1);
    check("wd_code", {254'd0, job_done_code}, 256'd3);
    check("wd_enable_off", {255'd0, asic_mining_enable}, 256'd0);
    check("wd_control_off", {248'd0, asic_control_reg}, 256'h00);
`else
    check("nowd_no_timeout", {255'd0, job_done}, 256'd0);
    repeat (130) @(negedge clk_100m);
    check("nowd_still_running", {255'd0, asic_mining_enable}, 256'd1);
    host_abort = 1'b1;
    @(negedge clk_100m);
    host_abort = 1'b0;
    check("nowd_abort_pulse", {255'd0, job_done}, 256'd1);
    check("nowd_abort_code", {254'd0, job_done_code}, 256'd3);
    check("nowd_enable_off", {255'd0, asic_mining_enable}, 256'd0);
`endif
    check("t3_jobs_completed", {240'd0, jobs_completed}, 256'd3);
    asic_pipeline_busy = 1'b0;
    @(negedge clk_100m);
    check("t3_back_idle", {255'd0, job_ready}, 256'd1);

    // Abort while a result is pending.
    start_job({8{32'hA5A5_0004}}, 32'h2000, 32'd64);
    asic_hash_valid = 1'b1;
    asic_found_nonce = 32'h2222;
    asic_found_hash = {8{32'h0000_2222}};
    @(negedge clk_100m);
    check("abort_pre_valid", {255'd0, result_valid}, 256'd1);
    check("abort_pre_nonce", {224'd0, result_nonce}, 256'h2222);
    host_abort = 1'b1;
    @(negedge clk_100m);
    host_abort = 1'b0;
    asic_hash_valid = 1'b0;
    asic_pipeline_busy = 1'b0;
    check("abort_result_dropped", {255'd0, result_valid}, 256'd0);
    check("abort_done_pulse", {255'd0, job_done}, 256'd1);
    check("abort_code", {254'd0, job_done_code}, 256'd3);
    check("abort_nonces_found", {240'd0, nonces_found}, 256'd1);
    check("abort_jobs_completed", {240'd0, jobs_completed}, 256'd4);
    @(negedge clk_100m);
    check("abort_back_idle", {255'd0, job_ready}, 256'd1);
    check("abort_done_one_cycle", {255'd0, job_done}, 256'd0);

    // Reset in the middle of RUN.
    start_job({8{32'hA5A5_0005}}, 32'h3000, 32'd8);
    reset = 1'b1;
    @(negedge clk_100m);
    check("mrst_job_ready", {255'd0, job_ready}, 256'd0);
    check("mrst_enable", {255'd0, asic_mining_enable}, 256'd0);
    check("mrst_control", {248'd0, asic_control_reg}, 256'h00);
    check("mrst_result_valid", {255'd0, result_valid}, 256'd0);
    check("mrst_result_nonce", {224'd0, result_nonce}, 256'd0);
    check("mrst_result_hash", result_hash, 256'd0);
    check("mrst_job_done", {255'd0, job_done}, 256'd0);
    check("mrst_code", {254'd0, job_done_code}, 256'd0);
    check("mrst_asic_header", asic_job_header, 256'd0);
    check("mrst_asic_nonce", {224'd0, asic_start_nonce}, 256'd0);
    check("mrst_asic_range", {224'd0, asic_nonce_range}, 256'd0);
    check("mrst_jobs_completed", {240'd0, jobs_completed}, 256'd0);
    check("mrst_nonces_found", {240'd0, nonces_found}, 256'd0);
    check("mrst_throttle", {240'd0, throttle_cycles}, 256'd0);
    reset = 1'b0;
    asic_pipeline_busy = 1'b0;
    @(negedge clk_100m);
    check("mrst_release_ready", {255'd0, job_ready}, 256'd1);
    check("mrst_release_enable", {255'd0, asic_mining_enable}, 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
